// File: rtl/mips_bus_mem_ctrl_if.sv
// CPU-side memory bus between a MIPS core (master) and the memory controller (slave).
interface mips_bus_mem_ctrl_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_mem_ctrl.sv
// Memory controller: decodes CPU bus requests onto a program RAM (0xBFC0_0000)
// and a stack RAM (0x0000_0000), both 4K words with 1-cycle read latency.
// Partial-byte writes are done as read-modify-write; illegal requests set a
// sticky fault flag and complete immediately with zero data.
module mips_bus_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  mips_bus_mem_ctrl_if.slave  bus,
  output logic [11:0]         prog_addr,
  output logic                prog_read,
  output logic                prog_write,
  output logic [31:0]         prog_writedata,
  input  logic [31:0]         prog_readdata,
  output logic [11:0]         stack_addr,
  output logic                stack_read,
  output logic                stack_write,
  output logic [31:0]         stack_writedata,
  input  logic [31:0]         stack_readdata,
  output logic                fault
);

  typedef enum logic [1:0] {IDLE, RMW, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        region_reg;     // 1 = program RAM, 0 = stack RAM
  logic        is_read_reg;
  logic [3:0]  cnt_reg;
  logic        first_reg;      // first WAIT cycle: RAM read data is valid now
  logic [31:0] data_reg;
  logic [31:0] readdata_reg;
  logic        fault_reg;

  // Request decode on the live bus inputs (only used while IDLE).
  logic req, in_stack, in_prog, illegal, be_full, be_none;
  assign req      = bus.read | bus.write;
  assign in_stack = bus.address < 32'h0000_4000;
  assign in_prog  = (bus.address >= 32'hBFC0_0000) && (bus.address < 32'hBFC0_4000);
  assign illegal  = (!in_stack && !in_prog) || (bus.address[1:0] != 2'b00) ||
                    (bus.read && bus.write);
  assign be_full  = bus.byteenable == 4'b1111;
  assign be_none  = bus.byteenable == 4'b0000;

  // Read data returned by whichever RAM the latched request targets.
  logic [31:0] ram_q;
  assign ram_q = region_reg ? prog_readdata : stack_readdata;

  // Byte-lane merge for read-modify-write.
  logic [31:0] merged;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : ram_q[8*gi +: 8];
  end

  // RAM strobes: issued from IDLE on acceptance and from RMW for the merged write.
  logic        ram_rd, ram_wr, tgt_prog;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  always_comb begin
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    tgt_prog  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (req && !illegal) begin
            tgt_prog = in_prog;
            ram_addr = bus.address[13:2];
            if (bus.read) begin
              ram_rd = 1'b1;
            end else if (be_full) begin
              ram_wr    = 1'b1;
              ram_wdata = bus.writedata;
            end else if (!be_none) begin
              ram_rd = 1'b1;
            end
          end
        end
        RMW: begin
          tgt_prog  = region_reg;
          ram_addr  = addr_reg;
          ram_wr    = 1'b1;
          ram_wdata = merged;
        end
        default: ;
      endcase
    end
  end

  // Route strobes to the addressed RAM only; the other RAM sees all zeros.
  always_comb begin
    prog_read       = ram_rd & tgt_prog;
    prog_write      = ram_wr & tgt_prog;
    stack_read      = ram_rd & ~tgt_prog;
    stack_write     = ram_wr & ~tgt_prog;
    prog_addr       = (prog_read | prog_write) ? ram_addr : 12'd0;
    stack_addr      = (stack_read | stack_write) ? ram_addr : 12'd0;
    prog_writedata  = prog_write ? ram_wdata : 32'd0;
    stack_writedata = stack_write ? ram_wdata : 32'd0;
  end

  // Transfer FSM: accept in IDLE, optional RMW, WAIT countdown, one DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      be_reg       <= '0;
      region_reg   <= 1'b0;
      is_read_reg  <= 1'b0;
      cnt_reg      <= '0;
      first_reg    <= 1'b0;
      data_reg     <= '0;
      readdata_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      readdata_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg    <= bus.address[13:2];
            wdata_reg   <= bus.writedata;
            be_reg      <= bus.byteenable;
            region_reg  <= in_prog;
            is_read_reg <= bus.read;
            cnt_reg     <= WAIT_INIT;
            first_reg   <= 1'b1;
            if (illegal) begin
              fault_reg <= 1'b1;
              state_reg <= DONE;
            end else if (bus.read || be_full) begin
              state_reg <= WAIT;
            end else if (be_none) begin
              state_reg <= DONE;
            end else begin
              state_reg <= RMW;
            end
          end
        end
        RMW: state_reg <= WAIT;
        WAIT: begin
          first_reg <= 1'b0;
          if (first_reg) data_reg <= ram_q;
          if (cnt_reg == 4'd0) begin
            state_reg <= DONE;
            if (is_read_reg) readdata_reg <= first_reg ? ram_q : data_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.waitrequest = !reset && req && (state_reg != DONE);
  assign bus.readdata    = readdata_reg;
  assign fault           = fault_reg;

endmodule
